alu_rs: RTL and testbench

Reservation station for the integer ALU, directly upstream of the ALU and its CDB broadcast stage. It holds dispatched ALU instructions, snoops the common data bus to resolve outstanding source tags, and issues one ready instruction per cycle to the ALU. Each entry stays allocated until the CDB stage returns a finish pulse carrying that entry's slot number.

---
 rtl/alu_rs.sv | 272 +++++++++++++++++++++++++++
 tb/tb_alu_rs.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs -- integer ALU reservation station.
//
// Holds dispatched ALU instructions until both source operands are present.
// It snoops the CDB to resolve outstanding source tags and issues at most one
// ready instruction per cycle to the ALU. A slot stays allocated after issue
// until the CDB stage returns a finish pulse that names the slot.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   flush                    mispredict flush, discards every entry
//   disp_*                   dispatch request: opcode, two sources, dest tag
//   rs_full                  all slots busy; dispatch is ignored while high
//   cdb_valid/tag/data       common data bus broadcast
//   alu_issue_valid          one-cycle issue pulse
//   alu_op/a/b/dest_tag      issued instruction (held while idle)
//   alu_rs_num               slot index of the issued entry
//   alu_finish/_num          release of a slot by the CDB stage
// ---------------------------------------------------------------------------
module alu_rs #(
   parameter int ENTRIES = 8,
   parameter int RS_W    = 3,
   parameter int TAG_W   = 4,
   parameter int DATA_W  = 32,
   parameter int OP_W    = 5,
   parameter logic [TAG_W-1:0] TAG_FREE = {TAG_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              disp_valid,
   input  logic [OP_W-1:0]   disp_op,
   input  logic [TAG_W-1:0]  disp_src1_tag,
   input  logic [DATA_W-1:0] disp_src1_data,
   input  logic [TAG_W-1:0]  disp_src2_tag,
   input  logic [DATA_W-1:0] disp_src2_data,
   input  logic [TAG_W-1:0]  disp_dest_tag,
   output logic              rs_full,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   output logic              alu_issue_valid,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [TAG_W-1:0]  alu_dest_tag,
   output logic [RS_W-1:0]   alu_rs_num,
   input  logic              alu_finish,
   input  logic [RS_W-1:0]   alu_finish_num
);

   // Slot state
   logic [ENTRIES-1:0] busy_q, busy_d;
   logic [ENTRIES-1:0] issued_q, issued_d;
   logic [OP_W-1:0]    op_q    [ENTRIES];
   logic [OP_W-1:0]    op_d    [ENTRIES];
   logic [TAG_W-1:0]   tag1_q  [ENTRIES];
   logic [TAG_W-1:0]   tag1_d  [ENTRIES];
   logic [DATA_W-1:0]  data1_q [ENTRIES];
   logic [DATA_W-1:0]  data1_d [ENTRIES];
   logic [TAG_W-1:0]   tag2_q  [ENTRIES];
   logic [TAG_W-1:0]   tag2_d  [ENTRIES];
   logic [DATA_W-1:0]  data2_q [ENTRIES];
   logic [DATA_W-1:0]  data2_d [ENTRIES];
   logic [TAG_W-1:0]   dest_q  [ENTRIES];
   logic [TAG_W-1:0]   dest_d  [ENTRIES];

   // Issue output registers
   logic              issue_valid_q, issue_valid_d;
   logic [OP_W-1:0]   out_op_q, out_op_d;
   logic [DATA_W-1:0] out_a_q, out_a_d;
   logic [DATA_W-1:0] out_b_q, out_b_d;
   logic [TAG_W-1:0]  out_dest_q, out_dest_d;
   logic [RS_W-1:0]   out_num_q, out_num_d;

   // Combinational helpers
   logic               rs_full_s;
   logic               alloc_en_s;
   logic [RS_W-1:0]    alloc_idx_s;
   logic [ENTRIES-1:0] ready_s;
   logic               sel_found_s;
   logic [RS_W-1:0]    sel_idx_s;
   logic [TAG_W-1:0]   src1_tag_s, src2_tag_s;
   logic [DATA_W-1:0]  src1_data_s, src2_data_s;

   assign rs_full_s  = &busy_q;
   assign alloc_en_s = disp_valid & ~rs_full_s & ~flush;

   assign rs_full         = rs_full_s;
   assign alu_issue_valid = issue_valid_q;
   assign alu_op          = out_op_q;
   assign alu_a           = out_a_q;
   assign alu_b           = out_b_q;
   assign alu_dest_tag    = out_dest_q;
   assign alu_rs_num      = out_num_q;

   // Lowest free slot; scanning downward leaves the lowest index last.
   always_comb begin
      alloc_idx_s = {RS_W{1'b0}};
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            alloc_idx_s = RS_W'(i);
         end else begin
            alloc_idx_s = alloc_idx_s;
         end
      end
   end

   // Ready vector and lowest-index select, from registered state only.
   always_comb begin
      ready_s   = {ENTRIES{1'b0}};
      sel_idx_s = {RS_W{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
         ready_s[i] = busy_q[i] & ~issued_q[i] &
                      (tag1_q[i] == TAG_FREE) & (tag2_q[i] == TAG_FREE);
      end
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (ready_s[i]) begin
            sel_idx_s = RS_W'(i);
         end else begin
            sel_idx_s = sel_idx_s;
         end
      end
      sel_found_s = |ready_s;
   end

   // Dispatch bypass: a source produced by this cycle's broadcast is captured now.
   always_comb begin
      if (cdb_valid && (disp_src1_tag != TAG_FREE) && (disp_src1_tag == cdb_tag)) begin
         src1_tag_s  = TAG_FREE;
         src1_data_s = cdb_data;
      end else begin
         src1_tag_s  = disp_src1_tag;
         src1_data_s = disp_src1_data;
      end
      if (cdb_valid && (disp_src2_tag != TAG_FREE) && (disp_src2_tag == cdb_tag)) begin
         src2_tag_s  = TAG_FREE;
         src2_data_s = cdb_data;
      end else begin
         src2_tag_s  = disp_src2_tag;
         src2_data_s = disp_src2_data;
      end
   end

   // Slot next state: wakeup, issue mark, release, allocation, then flush on top.
   always_comb begin
      busy_d   = busy_q;
      issued_d = issued_q;
      op_d     = op_q;
      tag1_d   = tag1_q;
      data1_d  = data1_q;
      tag2_d   = tag2_q;
      data2_d  = data2_q;
      dest_d   = dest_q;

      for (int i = 0; i < ENTRIES; i++) begin
         if (cdb_valid && busy_q[i] && (tag1_q[i] != TAG_FREE) && (tag1_q[i] == cdb_tag)) begin
            tag1_d[i]  = TAG_FREE;
            data1_d[i] = cdb_data;
         end else begin
            tag1_d[i]  = tag1_q[i];
            data1_d[i] = data1_q[i];
         end
         if (cdb_valid && busy_q[i] && (tag2_q[i] != TAG_FREE) && (tag2_q[i] == cdb_tag)) begin
            tag2_d[i]  = TAG_FREE;
            data2_d[i] = cdb_data;
         end else begin
            tag2_d[i]  = tag2_q[i];
            data2_d[i] = data2_q[i];
         end
      end

      if (sel_found_s) begin
         issued_d[sel_idx_s] = 1'b1;
      end else begin
         issued_d = issued_d;
      end

      // A finish naming a free slot is stale (e.g. from a flushed entry).
      if (alu_finish && busy_q[alu_finish_num]) begin
         busy_d[alu_finish_num]   = 1'b0;
         issued_d[alu_finish_num] = 1'b0;
      end else begin
         busy_d = busy_d;
      end

      if (alloc_en_s) begin
         busy_d[alloc_idx_s]   = 1'b1;
         issued_d[alloc_idx_s] = 1'b0;
         op_d[alloc_idx_s]     = disp_op;
         tag1_d[alloc_idx_s]   = src1_tag_s;
         data1_d[alloc_idx_s]  = src1_data_s;
         tag2_d[alloc_idx_s]   = src2_tag_s;
         data2_d[alloc_idx_s]  = src2_data_s;
         dest_d[alloc_idx_s]   = disp_dest_tag;
      end else begin
         busy_d = busy_d;
      end

      if (flush) begin
         busy_d   = {ENTRIES{1'b0}};
         issued_d = {ENTRIES{1'b0}};
      end else begin
         busy_d = busy_d;
      end
   end

   // Issue output next state; data outputs hold when nothing issues.
   always_comb begin
      issue_valid_d = sel_found_s & ~flush;
      if (sel_found_s && !flush) begin
         out_op_d   = op_q[sel_idx_s];
         out_a_d    = data1_q[sel_idx_s];
         out_b_d    = data2_q[sel_idx_s];
         out_dest_d = dest_q[sel_idx_s];
         out_num_d  = sel_idx_s;
      end else begin
         out_op_d   = out_op_q;
         out_a_d    = out_a_q;
         out_b_d    = out_b_q;
         out_dest_d = out_dest_q;
         out_num_d  = out_num_q;
      end
   end

   // Slot state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q   <= {ENTRIES{1'b0}};
         issued_q <= {ENTRIES{1'b0}};
         for (int i = 0; i < ENTRIES; i++) begin
            op_q[i]    <= {OP_W{1'b0}};
            tag1_q[i]  <= TAG_FREE;
            data1_q[i] <= {DATA_W{1'b0}};
            tag2_q[i]  <= TAG_FREE;
            data2_q[i] <= {DATA_W{1'b0}};
            dest_q[i]  <= TAG_FREE;
         end
      end else begin
         busy_q   <= busy_d;
         issued_q <= issued_d;
         for (int i = 0; i < ENTRIES; i++) begin
            op_q[i]    <= op_d[i];
            tag1_q[i]  <= tag1_d[i];
            data1_q[i] <= data1_d[i];
            tag2_q[i]  <= tag2_d[i];
            data2_q[i] <= data2_d[i];
            dest_q[i]  <= dest_d[i];
         end
      end
   end

   // Issue output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_valid_q <= 1'b0;
         out_op_q      <= {OP_W{1'b0}};
         out_a_q       <= {DATA_W{1'b0}};
         out_b_q       <= {DATA_W{1'b0}};
         out_dest_q    <= TAG_FREE;
         out_num_q     <= {RS_W{1'b0}};
      end else begin
         issue_valid_q <= issue_valid_d;
         out_op_q      <= out_op_d;
         out_a_q       <= out_a_d;
         out_b_q       <= out_b_d;
         out_dest_q    <= out_dest_d;
         out_num_q     <= out_num_d;
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// ---------------------------------------------------------------------------
// tb_alu_rs -- directed self-checking bench for alu_rs.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_alu_rs;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        disp_valid;
   logic [4:0]  disp_op;
   logic [3:0]  disp_src1_tag;
   logic [31:0] disp_src1_data;
   logic [3:0]  disp_src2_tag;
   logic [31:0] disp_src2_data;
   logic [3:0]  disp_dest_tag;
   logic        rs_full;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        alu_issue_valid;
   logic [4:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_dest_tag;
   logic [2:0]  alu_rs_num;
   logic        alu_finish;
   logic [2:0]  alu_finish_num;

   int tests_run;
   int tests_failed;

   alu_rs dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .disp_valid     (disp_valid),
      .disp_op        (disp_op),
      .disp_src1_tag  (disp_src1_tag),
      .disp_src1_data (disp_src1_data),
      .disp_src2_tag  (disp_src2_tag),
      .disp_src2_data (disp_src2_data),
      .disp_dest_tag  (disp_dest_tag),
      .rs_full        (rs_full),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .cdb_data       (cdb_data),
      .alu_issue_valid(alu_issue_valid),
      .alu_op         (alu_op),
      .alu_a          (alu_a),
      .alu_b          (alu_b),
      .alu_dest_tag   (alu_dest_tag),
      .alu_rs_num     (alu_rs_num),
      .alu_finish     (alu_finish),
      .alu_finish_num (alu_finish_num)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      disp_valid = 1'b0;
      cdb_valid  = 1'b0;
      alu_finish = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic set_disp(input logic [4:0] op, input logic [3:0] t1, input logic [31:0] d1,
                           input logic [3:0] t2, input logic [31:0] d2, input logic [3:0] dst);
      disp_valid     = 1'b1;
      disp_op        = op;
      disp_src1_tag  = t1;
      disp_src1_data = d1;
      disp_src2_tag  = t2;
      disp_src2_data = d2;
      disp_dest_tag  = dst;
   endtask

   task automatic do_finish(input logic [2:0] num);
      alu_finish     = 1'b1;
      alu_finish_num = num;
      tick();
      clr_in();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst = 1'b1;
      clr_in();
      disp_op = 5'd0; disp_src1_tag = 4'd0; disp_src1_data = 32'd0;
      disp_src2_tag = 4'd0; disp_src2_data = 32'd0; disp_dest_tag = 4'd0;
      cdb_tag = 4'd0; cdb_data = 32'd0; alu_finish_num = 3'd0;

      // Reset values
      tick();
      tick();
      check("rst_valid", {31'd0, alu_issue_valid}, 32'd0);
      check("rst_op",    {27'd0, alu_op}, 32'd0);
      check("rst_a",     alu_a, 32'd0);
      check("rst_b",     alu_b, 32'd0);
      check("rst_dest",  {28'd0, alu_dest_tag}, 32'd0);
      check("rst_num",   {29'd0, alu_rs_num}, 32'd0);
      check("rst_full",  {31'd0, rs_full}, 32'd0);
      rst = 1'b0;

      // Ready dispatch issues one cycle after the dispatch edge
      set_disp(5'd1, 4'd0, 32'd5, 4'd0, 32'd7, 4'd3);
      tick();
      clr_in();
      check("t1_early", {31'd0, alu_issue_valid}, 32'd0);
      tick();
      check("t1_valid", {31'd0, alu_issue_valid}, 32'd1);
      check("t1_op",    {27'd0, alu_op}, 32'd1);
      check("t1_a",     alu_a, 32'd5);
      check("t1_b",     alu_b, 32'd7);
      check("t1_dest",  {28'd0, alu_dest_tag}, 32'd3);
      check("t1_num",   {29'd0, alu_rs_num}, 32'd0);
      tick();
      check("t1_idle",  {31'd0, alu_issue_valid}, 32'd0);
      check("t1_hold",  alu_a, 32'd5);
      do_finish(3'd0);

      // CDB wakeup of src1
      set_disp(5'd2, 4'd6, 32'hDEAD, 4'd0, 32'd2, 4'd4);
      tick();
      clr_in();
      tick();
      check("t2_wait", {31'd0, alu_issue_valid}, 32'd0);
      cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'h1234;
      tick();
      clr_in();
      check("t2_early", {31'd0, alu_issue_valid}, 32'd0);
      tick();
      check("t2_valid", {31'd0, alu_issue_valid}, 32'd1);
      check("t2_a",     alu_a, 32'h1234);
      check("t2_b",     alu_b, 32'd2);
      check("t2_dest",  {28'd0, alu_dest_tag}, 32'd4);
      do_finish(3'd0);

      // Dispatch bypass of src2 from a same-cycle broadcast
      set_disp(5'd3, 4'd0, 32'd1, 4'd9, 32'hBEEF, 4'd5);
      cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'hAA;
      tick();
      clr_in();
      tick();
      check("t3_valid", {31'd0, alu_issue_valid}, 32'd1);
      check("t3_b",     alu_b, 32'hAA);
      check("t3_a",     alu_a, 32'd1);
      do_finish(3'd0);

      // Fill all eight slots; issues follow in slot order
      for (int k = 0; k < 8; k++) begin
         set_disp(5'd4, 4'd0, 32'd100 + 32'(k), 4'd0, 32'(k), 4'(k));
         tick();
         if (k > 0) begin
            check("t4_valid", {31'd0, alu_issue_valid}, 32'd1);
            check("t4_num",   {29'd0, alu_rs_num}, 32'(k - 1));
            check("t4_a",     alu_a, 32'd100 + 32'(k - 1));
         end
      end
      check("t4_full", {31'd0, rs_full}, 32'd1);
      set_disp(5'd4, 4'd0, 32'd999, 4'd0, 32'd0, 4'd0);
      tick();
      check("t4_last_num", {29'd0, alu_rs_num}, 32'd7);
      check("t4_last_a",   alu_a, 32'd107);
      clr_in();
      tick();
      check("t4_9th_drop", {31'd0, alu_issue_valid}, 32'd0);
      check("t4_still_full", {31'd0, rs_full}, 32'd1);
      do_finish(3'd2);
      check("t4_not_full", {31'd0, rs_full}, 32'd0);
      set_disp(5'd4, 4'd0, 32'd222, 4'd0, 32'd0, 4'd1);
      tick();
      clr_in();
      check("t4_refull", {31'd0, rs_full}, 32'd1);
      tick();
      check("t4_re_valid", {31'd0, alu_issue_valid}, 32'd1);
      check("t4_re_num",   {29'd0, alu_rs_num}, 32'd2);
      check("t4_re_a",     alu_a, 32'd222);
      for (int k = 0; k < 8; k++) begin
         do_finish(3'(k));
      end
      check("t4_empty", {31'd0, rs_full}, 32'd0);

      // Slots 1 and 4 wake on one broadcast; slot 1 issues first
      set_disp(5'd5, 4'd10, 32'd0, 4'd0, 32'h00, 4'd8);
      tick();
      set_disp(5'd5, 4'd11, 32'd0, 4'd0, 32'h11, 4'd1);
      tick();
      set_disp(5'd5, 4'd10, 32'd0, 4'd0, 32'h22, 4'd8);
      tick();
      set_disp(5'd5, 4'd10, 32'd0, 4'd0, 32'h33, 4'd8);
      tick();
      set_disp(5'd5, 4'd11, 32'd0, 4'd0, 32'h44, 4'd2);
      tick();
      clr_in();
      check("t5_none", {31'd0, alu_issue_valid}, 32'd0);
      cdb_valid = 1'b1; cdb_tag = 4'd11; cdb_data = 32'h55;
      tick();
      clr_in();
      check("t5_early", {31'd0, alu_issue_valid}, 32'd0);
      tick();
      check("t5_first_valid", {31'd0, alu_issue_valid}, 32'd1);
      check("t5_first_num",   {29'd0, alu_rs_num}, 32'd1);
      check("t5_first_a",     alu_a, 32'h55);
      check("t5_first_b",     alu_b, 32'h11);
      tick();
      check("t5_second_valid", {31'd0, alu_issue_valid}, 32'd1);
      check("t5_second_num",   {29'd0, alu_rs_num}, 32'd4);
      check("t5_second_b",     alu_b, 32'h44);
      check("t5_second_dest",  {28'd0, alu_dest_tag}, 32'd2);
      tick();
      check("t5_idle", {31'd0, alu_issue_valid}, 32'd0);
      do_finish(3'd5);
      check("t5_dup_valid", {31'd0, alu_issue_valid}, 32'd0);
      check("t5_dup_full",  {31'd0, rs_full}, 32'd0);
      do_finish(3'd1);
      do_finish(3'd4);

      // Flush with a concurrent dispatch and a pending issue
      set_disp(5'd6, 4'd0, 32'h66, 4'd0, 32'd0, 4'd5);
      tick();
      clr_in();
      flush = 1'b1;
      set_disp(5'd6, 4'd0, 32'h77, 4'd0, 32'd0, 4'd7);
      tick();
      clr_in();
      check("t6_flush_valid", {31'd0, alu_issue_valid}, 32'd0);
      check("t6_flush_full",  {31'd0, rs_full}, 32'd0);
      tick();
      check("t6_no_disp", {31'd0, alu_issue_valid}, 32'd0);
      cdb_valid = 1'b1; cdb_tag = 4'd10; cdb_data = 32'h99;
      tick();
      clr_in();
      tick();
      check("t6_no_wake", {31'd0, alu_issue_valid}, 32'd0);
      set_disp(5'd7, 4'd0, 32'h88, 4'd0, 32'd0, 4'd6);
      tick();
      clr_in();
      tick();
      check("t6_after_valid", {31'd0, alu_issue_valid}, 32'd1);
      check("t6_after_num",   {29'd0, alu_rs_num}, 32'd0);
      check("t6_after_a",     alu_a, 32'h88);

      // Asynchronous reset mid-cycle
      #2;
      rst = 1'b1;
      #1;
      check("t7_valid", {31'd0, alu_issue_valid}, 32'd0);
      check("t7_a",     alu_a, 32'd0);
      check("t7_op",    {27'd0, alu_op}, 32'd0);
      check("t7_dest",  {28'd0, alu_dest_tag}, 32'd0);
      check("t7_num",   {29'd0, alu_rs_num}, 32'd0);
      check("t7_full",  {31'd0, rs_full}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("t7_after", {31'd0, alu_issue_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
